// File: rtl/select_index_reader_pkg.sv
// Shared types and constants for the select-index reader.
package select_index_reader_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/select_index_reader_mux.sv
// Dual-port bit selection: vec[idx] and its mirror vec[~idx].
module select_index_reader_mux
   import select_index_reader_pkg::*;
#(
   parameter  int unsigned WIDTH = WIDTH_DEFAULT,
   localparam int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   input  logic [IDXW-1:0]  idx,
   output logic             sel_bit,
   output logic             flip_bit
);

   logic [IDXW-1:0] idx_flip;

   // For power-of-two WIDTH, ~idx is exactly WIDTH-1-idx.
   assign idx_flip = ~idx;
   assign sel_bit  = vec[idx];
   assign flip_bit = vec[idx_flip];

endmodule

// File: rtl/select_index_reader.sv
// Loads a vector, then streams WIDTH beats of (index, bit, mirrored bit).
// Optional read-to-clear behaviour: define SELECT_INDEX_READER_CLEAR_EN.
module select_index_reader
   import select_index_reader_pkg::*;
#(
   parameter  int unsigned WIDTH = WIDTH_DEFAULT,
   localparam int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [IDXW-1:0]  load_start,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_index,
   output logic             out_bit,
   output logic             out_bit_flip,
   output logic             out_last
);

   localparam logic [IDXW:0] CNT_LAST = (IDXW+1)'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] vec;
   logic [IDXW-1:0]  idx;
   logic [IDXW:0]    cnt;
   logic             load_hs;
   logic             out_hs;

   assign load_hs  = load_valid && load_ready;
   assign out_hs   = out_valid && out_ready;
   assign out_last = out_valid && (cnt == CNT_LAST);
   assign out_index = idx;

   select_index_reader_mux #(
      .WIDTH (WIDTH)
   ) u_mux (
      .vec      (vec),
      .idx      (idx),
      .sel_bit  (out_bit),
      .flip_bit (out_bit_flip)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         vec        <= '0;
         idx        <= '0;
         cnt        <= '0;
         load_ready <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_hs) begin
                  vec        <= load_data;
                  idx        <= load_start;
                  cnt        <= '0;
                  state      <= SCAN;
                  load_ready <= 1'b0;
                  out_valid  <= 1'b1;
               end
            end
            SCAN: begin
               if (out_hs) begin
                  idx <= idx + 1'b1;
                  cnt <= cnt + 1'b1;
`ifdef SELECT_INDEX_READER_CLEAR_EN
                  vec[idx]  <= 1'b0;
                  vec[~idx] <= 1'b0;
`endif
                  if (cnt == CNT_LAST) begin
                     state      <= IDLE;
                     load_ready <= 1'b1;
                     out_valid  <= 1'b0;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               load_ready <= 1'b1;
               out_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_select_index_reader.sv
// Directed bench for select_index_reader (WIDTH = 8), both macro settings.
module tb_select_index_reader;

   localparam int unsigned W  = 8;
   localparam int unsigned IW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_valid;
   logic          load_ready;
   logic [W-1:0]  load_data;
   logic [IW-1:0] load_start;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_index;
   logic          out_bit;
   logic          out_bit_flip;
   logic          out_last;

   int n_assert = 0;
   int n_fail   = 0;

   select_index_reader #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .load_start   (load_start),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_index    (out_index),
      .out_bit      (out_bit),
      .out_bit_flip (out_bit_flip),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while IDLE; returns at the negedge of the first beat.
   task automatic do_load(input logic [W-1:0] data, input logic [IW-1:0] start);
      chk("load_ready_idle", load_ready, 1'b1);
      load_data  = data;
      load_start = start;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   // Checks nbeats handshakes of a scan that started with vector data at start.
   task automatic scan_beats(input logic [W-1:0] data, input int start,
                             input int nbeats, input bit bp);
      logic [W-1:0]  vecm;
      logic [IW-1:0] i;
      bit            pat [4];
      int            beats;
      int            cyc;
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
      vecm  = data;
      beats = 0;
      cyc   = 0;
      while (beats < nbeats && cyc < 64) begin
         i = IW'(start + beats);
         chk("scan_valid", out_valid, 1'b1);
         chk("scan_ready_low", load_ready, 1'b0);
         chk("scan_index", out_index, i);
         chk("scan_bit", out_bit, vecm[i]);
         chk("scan_flip", out_bit_flip, vecm[W-1-i]);
         chk("scan_last", out_last, beats == W-1);
         out_ready = bp ? pat[cyc % 4] : 1'b1;
         if (out_ready) begin
`ifdef SELECT_INDEX_READER_CLEAR_EN
            vecm[i]     = 1'b0;
            vecm[W-1-i] = 1'b0;
`endif
            beats++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("scan_handshakes", beats, nbeats);
      out_ready = 1'b0;
   endtask

   initial begin
      int unsigned exp_idx  [8];
      bit          exp_bit  [8];
      bit          exp_flip [8];
      bit          exp_after;

      exp_idx  = '{1, 2, 3, 4, 5, 6, 7, 0};
      exp_bit  = '{1, 1, 0, 0, 0, 0, 0, 0};
`ifdef SELECT_INDEX_READER_CLEAR_EN
      exp_flip  = '{0, 0, 0, 0, 0, 0, 0, 0};
      exp_after = 1'b0;
`else
      exp_flip  = '{0, 0, 0, 0, 1, 1, 0, 0};
      exp_after = 1'b1;
`endif

      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_start = '0;
      out_ready  = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_load_ready", load_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_index", out_index, 3'd0);
      chk("rst_out_bit", out_bit, 1'b0);
      chk("rst_out_flip", out_bit_flip, 1'b0);

      // Basic scan against hand-computed tables
      do_load(8'b0000_0110, 3'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("basic_valid", out_valid, 1'b1);
         chk("basic_index", out_index, exp_idx[k]);
         chk("basic_bit", out_bit, exp_bit[k]);
         chk("basic_flip", out_bit_flip, exp_flip[k]);
         chk("basic_last", out_last, k == 7);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("basic_done_ready", load_ready, 1'b1);
      chk("basic_done_valid", out_valid, 1'b0);
      chk("basic_done_last", out_last, 1'b0);
      // idx has wrapped back to 1; vec[1] survives only without read-to-clear
      chk("basic_done_index", out_index, 3'd1);
      chk("basic_done_bit", out_bit, exp_after);

      // Backpressure with out_ready pattern 1,0,0,1
      do_load(8'hA5, 3'd3);
      scan_beats(8'hA5, 3, 8, 1'b1);
      chk("bp_done_ready", load_ready, 1'b1);
      chk("bp_done_valid", out_valid, 1'b0);

      // Load offered throughout a scan is held off until IDLE
      do_load(8'h3C, 3'd0);
      load_data  = 8'hF0;
      load_start = 3'd5;
      load_valid = 1'b1;
      scan_beats(8'h3C, 0, 8, 1'b0);
      chk("hold_ready_back", load_ready, 1'b1);
      chk("hold_valid_low", out_valid, 1'b0);
      @(negedge clk);
      load_valid = 1'b0;
      scan_beats(8'hF0, 5, 8, 1'b0);
      chk("hold2_ready_back", load_ready, 1'b1);

      // Reset mid-scan with a simultaneous output handshake
      do_load(8'h5A, 3'd2);
      scan_beats(8'h5A, 2, 3, 1'b0);
      out_ready = 1'b1;
      reset     = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b0;
      chk("abort_valid", out_valid, 1'b0);
      chk("abort_ready", load_ready, 1'b1);
      chk("abort_last", out_last, 1'b0);
      chk("abort_index", out_index, 3'd0);
      repeat (2) @(negedge clk);
      chk("abort_stays_idle", out_valid, 1'b0);
      do_load(8'h81, 3'd7);
      scan_beats(8'h81, 7, 8, 1'b0);
      chk("wrap_done_ready", load_ready, 1'b1);
      chk("wrap_done_valid", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/select_index_reader.md
SELECT_INDEX_READER -- requirements
Module: select_index_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, vector width; power of two, 2 to 64.
REQ-002 The block SHALL have localparam IDXW = log2(WIDTH), index width.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port load_valid, input, 1 bit: load request.
REQ-006 The block SHALL have port load_ready, output, 1 bit: block can accept a load.
REQ-007 The block SHALL have port load_data, input, WIDTH bits: vector to scan.
REQ-008 The block SHALL have port load_start, input, IDXW bits: first index to read.
REQ-009 The block SHALL have port out_valid, output, 1 bit: read beat available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the beat.
REQ-011 The block SHALL have port out_index, output, IDXW bits: index read this beat.
REQ-012 The block SHALL have port out_bit, output, 1 bit: vec[out_index].
REQ-013 The block SHALL have port out_bit_flip, output, 1 bit: vec[~out_index].
REQ-014 The block SHALL have port out_last, output, 1 bit: final beat of the scan.

Function
REQ-015 The FSM SHALL have two states: IDLE and SCAN.
REQ-016 In IDLE, load_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 In SCAN, load_ready SHALL be 0 and out_valid SHALL be 1.
REQ-018 On a load handshake (load_valid && load_ready), the block SHALL capture load_data into vec, set idx = load_start and cnt = 0, and enter SCAN on the next cycle.
REQ-019 A load offered in SCAN SHALL be held off (not accepted) until the block returns to IDLE; there SHALL be no bypass.
REQ-020 out_index, out_bit and out_bit_flip SHALL be combinational from the registered vec and idx.
REQ-021 On an output handshake, idx SHALL increment by 1 modulo WIDTH, with wrap from WIDTH-1 to 0.
REQ-022 The beat presented SHALL always use the pre-increment (old) idx.
REQ-023 out_bit_flip SHALL read bit ~idx, i.e. WIDTH-1-idx.
REQ-024 out_last SHALL equal out_valid && (cnt == WIDTH-1).
REQ-025 The handshake of the last beat SHALL return the FSM to IDLE.
REQ-026 A scan SHALL always consist of exactly WIDTH beats.
REQ-027 While out_ready = 0 in SCAN, all outputs, idx, cnt and vec SHALL hold.
REQ-028 cnt SHALL be IDXW+1 bits wide and SHALL never wrap within a scan.

Reset
REQ-029 When reset is high at a rising clk edge, the block SHALL set state = IDLE and vec, idx, cnt = 0.
REQ-030 After reset, outputs SHALL be: load_ready = 1, out_valid = 0, out_last = 0, out_index = 0, out_bit = 0, out_bit_flip = 0.
REQ-031 Reset asserted mid-scan SHALL abort the scan; no further beats SHALL be emitted.
REQ-032 Reset SHALL take priority over any simultaneous load or output handshake.

Configuration
REQ-033 The feature macro SHALL be SELECT_INDEX_READER_CLEAR_EN.
REQ-034 With SELECT_INDEX_READER_CLEAR_EN defined, each output handshake SHALL clear vec[idx] and vec[~idx] in the same edge that advances idx (read-to-clear).
REQ-035 With the macro defined, a read at an index cleared by an earlier beat SHALL return 0.
REQ-036 With the macro defined, when idx == ~idx cannot occur (WIDTH >= 2), the two clears SHALL target distinct bits.
REQ-037 Without SELECT_INDEX_READER_CLEAR_EN, vec SHALL be unchanged throughout a scan.

Structure
REQ-038 Package select_index_reader_pkg SHALL hold the state enum (IDLE, SCAN) and the WIDTH_DEFAULT constant (8).
REQ-039 One sub-module, select_index_reader_mux, SHALL provide the dual-port bit selection (vec, idx -> bit, flip bit).
REQ-040 All other logic SHALL reside in the top module.

Verification
REQ-041 Reset: 3 cycles of reset, then -> load_ready = 1, out_valid = 0, all other outputs 0.
REQ-042 Basic scan (macro off): WIDTH = 8, load_data = 8'b0000_0110, load_start = 1, out_ready held 1 -> out_index sequence 1,2,3,4,5,6,7,0; out_bit sequence 1,1,0,0,0,0,0,0; out_bit_flip sequence 0,0,0,0,1,1,0,0; out_last only on the index-0 beat; load_ready returns to 1 on the following cycle.
REQ-043 Read-to-clear: same stimulus as REQ-042 with SELECT_INDEX_READER_CLEAR_EN defined -> out_bit sequence 1,1,0,0,0,0,0,0; out_bit_flip all 0; vec = 0 after the scan.
REQ-044 Backpressure: out_ready toggles 1,0,0,1,... -> each beat held stable while stalled; exactly 8 handshakes; no index skipped or repeated.
REQ-045 Load during scan: load_valid held high throughout a scan -> load_ready = 0 until the cycle after out_last handshakes; second vector then accepted and scanned from its load_start.
REQ-046 Reset mid-scan: assert reset after beat 3 -> out_valid = 0 on the next cycle; new load with load_start = 7 -> sequence 7,0,1,... wraps correctly.
